// File: rtl/rv32i_types.sv
// Shared RV32I core types: opcodes, the IF/ID pipeline payload and the fetch FSM states.
package rv32i_types;

   typedef enum logic [6:0] {
      op_b_lui   = 7'b0110111,
      op_b_auipc = 7'b0010111,
      op_b_jal   = 7'b1101111,
      op_b_jalr  = 7'b1100111,
      op_b_br    = 7'b1100011,
      op_b_load  = 7'b0000011,
      op_b_store = 7'b0100011,
      op_b_imm   = 7'b0010011,
      op_b_reg   = 7'b0110011
   } rv32i_opcode;

   typedef struct packed {
      logic [31:0] pc;
      logic        branch_pred;
      logic [31:0] predicted_pc;
      logic        monitor_valid;
      logic [63:0] monitor_order;
      logic [31:0] monitor_pc_rdata;
      logic [31:0] monitor_pc_wdata;
   } if_id_reg_t;

   typedef enum logic [1:0] {
      S_ISSUE,
      S_WAIT,
      S_HOLD,
      S_DROP
   } fetch_state_t;

   localparam logic [3:0] RMASK_WORD = 4'hF;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_static_predictor.sv
// Combinational next-PC predictor for the fetch stage.
// IF_STATIC_PRED_EN defined: conditional branches with a negative offset are
// predicted taken (backward loops); everything else falls through to pc + 4.
module if_static_predictor
   import rv32i_types::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   output logic        branch_pred,
   output logic [31:0] predicted_pc
);

`ifdef IF_STATIC_PRED_EN
   logic [31:0] b_imm;
   logic        is_br;

   // Backward-taken decision from the B-type immediate sign bit
   always_comb begin
      b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      is_br = (inst[6:0] == op_b_br);
      if (is_br && inst[31]) begin
         branch_pred  = 1'b1;
         predicted_pc = pc + b_imm;
      end else begin
         branch_pred  = 1'b0;
         predicted_pc = pc + 32'd4;
      end
   end
`else
   logic unused_inst;
   assign unused_inst = ^inst;

   // Always fall through
   always_comb begin
      branch_pred  = 1'b0;
      predicted_pc = pc + 32'd4;
   end
`endif

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one imem read in flight,
// buffers one instruction across decode stalls and squashes fetches on redirect.
// Static backward-taken prediction is enabled by defining IF_STATIC_PRED_EN.
//
// state   | meaning
// S_ISSUE | no request outstanding; issue at pc (or redirect_pc)
// S_WAIT  | one request outstanding, its response is wanted
// S_HOLD  | decode stalled; instruction held locally, nothing outstanding
// S_DROP  | one request outstanding, its response is stale and will be dropped
module if_stage
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   output logic [3:0]  imem_rmask,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   output logic [31:0] inst,
   output logic        if_id_valid,
   output if_id_reg_t  if_id_reg
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [63:0]  order_q, order_d;
   logic [31:0]  hold_inst_q, hold_inst_d;
   logic [31:0]  hold_pc_q, hold_pc_d;
   logic [31:0]  hold_ppc_q, hold_ppc_d;
   logic         hold_bp_q, hold_bp_d;

   logic [31:0]  redir_al;
   logic         pred_bp;
   logic [31:0]  pred_pc;
   logic         issue;
   logic [31:0]  issue_addr;
   logic         accept;
   logic [31:0]  cur_pc;
   logic [31:0]  cur_ppc;
   logic         cur_bp;

   assign redir_al = word_align(redirect_pc);

   // The predictor only ever sees the live response; held words carry their prediction
   if_static_predictor u_pred (
      .pc           (pc_q),
      .inst         (imem_rdata),
      .branch_pred  (pred_bp),
      .predicted_pc (pred_pc)
   );

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ISSUE;
         pc_q        <= RESET_PC;
         order_q     <= 64'd0;
         hold_inst_q <= 32'd0;
         hold_pc_q   <= 32'd0;
         hold_ppc_q  <= 32'd0;
         hold_bp_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         order_q     <= order_d;
         hold_inst_q <= hold_inst_d;
         hold_pc_q   <= hold_pc_d;
         hold_ppc_q  <= hold_ppc_d;
         hold_bp_q   <= hold_bp_d;
      end
   end

   // Next state, next pc, hold capture and retire counter
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      order_d     = accept ? order_q + 64'd1 : order_q;
      hold_inst_d = hold_inst_q;
      hold_pc_d   = hold_pc_q;
      hold_ppc_d  = hold_ppc_q;
      hold_bp_d   = hold_bp_q;
      case (state_q)
         S_ISSUE: begin
            pc_d    = issue_addr;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d    = redir_al;
               state_d = imem_resp ? S_WAIT : S_DROP;
            end else if (imem_resp) begin
               if (stall) begin
                  hold_inst_d = imem_rdata;
                  hold_pc_d   = pc_q;
                  hold_ppc_d  = pred_pc;
                  hold_bp_d   = pred_bp;
                  state_d     = S_HOLD;
               end else begin
                  pc_d = pred_pc;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = redir_al;
               state_d = S_WAIT;
            end else if (!stall) begin
               pc_d    = hold_ppc_q;
               state_d = S_WAIT;
            end
         end
         S_DROP: begin
            if (redirect) pc_d = redir_al;
            if (imem_resp) state_d = S_ISSUE;
         end
         default: state_d = S_ISSUE;
      endcase
   end

   // Request issue and IF/ID presentation; redirect kills valid, reset kills everything
   always_comb begin
      issue       = 1'b0;
      issue_addr  = pc_q;
      if_id_valid = 1'b0;
      inst        = imem_rdata;
      cur_pc      = pc_q;
      cur_ppc     = pred_pc;
      cur_bp      = pred_bp;
      if (!rst) begin
         case (state_q)
            S_ISSUE: begin
               issue      = 1'b1;
               issue_addr = redirect ? redir_al : pc_q;
            end
            S_WAIT: begin
               if (redirect) begin
                  if (imem_resp) begin
                     issue      = 1'b1;
                     issue_addr = redir_al;
                  end
               end else if (imem_resp) begin
                  if_id_valid = 1'b1;
                  if (!stall) begin
                     issue      = 1'b1;
                     issue_addr = pred_pc;
                  end
               end
            end
            S_HOLD: begin
               inst    = hold_inst_q;
               cur_pc  = hold_pc_q;
               cur_ppc = hold_ppc_q;
               cur_bp  = hold_bp_q;
               if (redirect) begin
                  issue      = 1'b1;
                  issue_addr = redir_al;
               end else begin
                  if_id_valid = 1'b1;
                  if (!stall) begin
                     issue      = 1'b1;
                     issue_addr = hold_ppc_q;
                  end
               end
            end
            default: ;
         endcase
      end
      accept                     = if_id_valid & ~stall;
      imem_addr                  = issue ? issue_addr : pc_q;
      imem_rmask                 = issue ? RMASK_WORD : 4'h0;
      if_id_reg.pc               = cur_pc;
      if_id_reg.branch_pred      = cur_bp;
      if_id_reg.predicted_pc     = cur_ppc;
      if_id_reg.monitor_valid    = if_id_valid;
      if_id_reg.monitor_order    = order_q;
      if_id_reg.monitor_pc_rdata = cur_pc;
      if_id_reg.monitor_pc_wdata = cur_ppc;
   end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined core, directly upstream of the decode stage. It owns the PC register and issues one-outstanding instruction-memory reads. It presents each returned instruction word, with its `if_id_reg_t` metadata, to the IF/ID pipeline register. It absorbs decode stalls with a one-entry hold buffer and squashes in-flight fetches on redirects from execute.

## Interface

Parameters:
- `RESET_PC`, default `32'h1eceb000`: PC value loaded on reset.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset; synchronous, active-high.
- `stall` in 1: IF/ID register not accepting this cycle.
- `redirect` in 1: execute-stage mispredict or jump.
- `redirect_pc` in 32: target when `redirect` is high.
- `imem_addr` out 32: fetch address, word aligned.
- `imem_rmask` out 4: `4'hF` for exactly one cycle per request, else `0`.
- `imem_rdata` in 32: returned instruction word.
- `imem_resp` in 1: response strobe, one cycle, at least 1 cycle after the request.
- `inst` out 32: instruction word to decode.
- `if_id_valid` out 1: `inst` and `if_id_reg` are valid this cycle.
- `if_id_reg` out `if_id_reg_t`: pc, `branch_pred`, `predicted_pc`, rvfi `monitor_valid`, `monitor_order`, `monitor_pc_rdata`, `monitor_pc_wdata`.

## Operation

State machine `fetch_state_t`:
- `S_ISSUE`
  - Issue a request at `pc` (or at `redirect_pc` if `redirect`, which also loads `pc`), then go to `S_WAIT`.
  - `imem_resp` is ignored in this state.
- `S_WAIT`: request outstanding.
  - `redirect` with no resp: `pc <= redirect_pc`, go to `S_DROP`.
  - `redirect` with resp: drop the word, issue at `redirect_pc` in the same cycle, stay in `S_WAIT`.
  - resp and no redirect: `if_id_valid=1`, outputs driven combinationally from `imem_rdata`.
    - `stall=0`: accepted; `pc <= predicted_pc`; issue at `predicted_pc` in the same cycle; stay in `S_WAIT`.
    - `stall=1`: capture word, pc, `predicted_pc` and `branch_pred` into the hold register; go to `S_HOLD`.
- `S_HOLD`: `if_id_valid=1` from the hold register; no request outstanding.
  - `redirect`: suppress `if_id_valid`, issue at `redirect_pc`, go to `S_WAIT`.
  - `stall=0`: accepted; issue at the held `predicted_pc`; go to `S_WAIT`.
- `S_DROP`: waiting for the stale response.
  - On resp: discard it, go to `S_ISSUE`.
  - `redirect`: reload `pc` only.

Other rules:
- `redirect` has priority over `stall` and over valid output. `if_id_valid` is forced to 0 in any cycle with `redirect=1`.
- Accept means `if_id_valid & ~stall & ~redirect`.
- A 64-bit `order` counter increments on each accept.
- rvfi fields:
  - `monitor_order = order`.
  - `monitor_valid = if_id_valid`.
  - `monitor_pc_rdata = pc` of the presented instruction.
  - `monitor_pc_wdata = predicted_pc`.
- `predicted_pc` arithmetic is 32-bit modulo; wrap-around at `32'hFFFFFFFC` to `0` is not flagged.
- `imem_addr` is driven to `pc` whenever no request is issued; it is don't-care for memory.

## Timing

- Reset values:
  - state `S_ISSUE`, `pc=RESET_PC`, `order=0`, hold register cleared.
  - `if_id_valid=0`, `imem_rmask=0` during the reset cycle.
- First request: the cycle after `rst` deasserts.
- Latency: an instruction is presented in the same cycle its `imem_resp` arrives.
- Throughput: one instruction per memory round-trip; the next request issues in the accept cycle, with no bubble.
- Hold release: the next request issues in the cycle `stall` falls; the held instruction is accepted in that same cycle.
- Simultaneous `redirect` and `imem_resp` in `S_WAIT`: the word is discarded and the new request issues that cycle.
- Reset mid-request: `rst` overrides all. The memory is reset together with the core, so no stale response is expected; `S_ISSUE` ignores resp regardless.

## Configuration

- `IF_STATIC_PRED_EN` defined: backward-taken static prediction.
  - For opcode `op_b_br` with negative B-immediate: `branch_pred=1`, `predicted_pc = pc + b_imm`.
  - For all other instructions: `branch_pred=0`, `predicted_pc = pc + 4`.
- `IF_STATIC_PRED_EN` undefined: always `branch_pred=0`, `predicted_pc = pc + 4`.

## Structure

- Shared package `rv32i_types`:
  - add `fetch_state_t`;
  - reuse `if_id_reg_t` and `op_b_br`.
- Sub-module `if_static_predictor`, combinational:
  - inputs `pc` and `inst`; outputs `branch_pred` and `predicted_pc`;
  - contains the macro-gated logic.

## Test plan

- Reset, then memory responds 2 cycles after each request, `stall=0`:
  - fetches go to `1eceb000`, `1eceb004`, `1eceb008`;
  - `monitor_order` reads 0, 1, 2 on the accepts.
- `stall=1` for 3 cycles on the resp of `1eceb004`:
  - `if_id_valid` is held with the same `inst` and pc for all 3 cycles;
  - no `imem_rmask` pulse while held;
  - `rmask` pulses at `1eceb008` when `stall` falls.
- `redirect` to `1eceb100` one cycle before a pending resp:
  - that resp is discarded with `if_id_valid=0`;
  - the next request goes to `1eceb100`.
- `redirect` to `1eceb200` in the same cycle as resp with `stall=1`:
  - `if_id_valid=0`, no state goes to `S_HOLD`;
  - `rmask` pulses at `1eceb200` that cycle.
- With `IF_STATIC_PRED_EN`, `beq` at `1eceb010` with offset -16:
  - `branch_pred=1`, `predicted_pc=1eceb000`, next fetch at `1eceb000`.
  - Without the macro: `branch_pred=0`, next fetch at `1eceb014`.
- Assert `rst` while in `S_WAIT`:
  - the next cycle has `pc=RESET_PC` and `order=0`;
  - a resp arriving in that cycle produces no valid output.
